line_window_3_3: RTL and testbench
==================================

# line_window_3_3

Sliding-window generator that sits directly upstream of the 3×3 convolution stage. It accepts a raster-order pixel stream, one 16-bit pixel per accepted cycle, and buffers the two previous image rows. For every input pixel that completes a full 3×3 neighbourhood, it emits that neighbourhood as a 144-bit patch. The patch is packed in exactly the order the convolution stage expects on its PATCH input.

## Interface
- IMG_W, default 8: image width in pixels; must be ≥ 3.
- IMG_H, default 8: image height in pixels; must be ≥ 3.
- DW, default 16: pixel width; the patch is 9*DW bits wide.

- CLK, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- PIX_IN, input, DW: input pixel.
- PIX_VALID, input, 1: PIX_IN is accepted on this cycle.
- SOF, input, 1: start of frame. Qualified by PIX_VALID, it marks the accepted pixel as position (0,0).
- PATCH, output, 9*DW: 3×3 window, registered.
- PATCH_VALID, output, 1: PATCH holds a new window this cycle (one-cycle pulse per window).
- ROW_O, output, clog2(IMG_H): row index of the window's bottom-right pixel.
- COL_O, output, clog2(IMG_W): column index of the window's bottom-right pixel.

## Operation
- **Position counters.** `col` and `row` give the position of the next pixel to accept.
  - On an accept, `col` increments. When `col` reaches IMG_W-1, it wraps to 0 and `row` increments.
  - When `row` and `col` are both at their last value (IMG_H-1, IMG_W-1), both wrap to 0, ready for the next frame.
- **Line buffers.** Two RAMs, LB0 and LB1, each IMG_W×DW, both addressed by `col`.
  - LB1 holds row r-2. LB0 holds row r-1.
  - On an accept, the old LB0[col] is written into LB1[col], and PIX_IN is written into LB0[col].
- **Window registers.** A 3×3 register array is shifted left by one column on each accept.
  - The new right column is {LB1[col], LB0[col], PIX_IN}, taken from values read before the write.
  - No window shift happens and no buffer is written on a cycle without PIX_VALID. All state holds.
- **Packing.** PATCH[9*DW-1 -: DW] is the top-left pixel p(r-2,c-2). Pixels then follow row-major. PATCH[DW-1:0] is the bottom-right pixel p(r,c). This matches conv ordering, where element 0 is in the MSBs.
- **PATCH_VALID condition.** PATCH_VALID is asserted for the accepted pixel (r,c) only when r ≥ 2 and c ≥ 2. Windows never straddle rows: stale columns left at the start of a row are masked by this condition.
- **SOF.**
  - If PIX_VALID and SOF, the pixel is treated as (0,0), whatever the counter state.
  - The counters then continue from (0,1). Line-buffer contents are not cleared; they are masked by the row condition.
  - SOF without PIX_VALID is ignored.
- **Frame count.** Each complete frame yields (IMG_W-2)*(IMG_H-2) windows.
- **Arithmetic.** No arithmetic is performed on pixel data; there is no saturation or sign handling.

## Timing
- **Latency.** PATCH, PATCH_VALID, ROW_O and COL_O update one cycle after the accept edge. For an accept at edge N, outputs are valid after edge N+1.
- **Throughput.** One pixel per cycle with no bubbles. There is no backpressure; downstream must consume every PATCH_VALID pulse.
- **Hold.** PATCH holds its last value while PATCH_VALID is low.
- **Reset.** While rst is high at an edge:
  - `row`, `col`, PATCH, PATCH_VALID, ROW_O and COL_O are cleared to 0.
  - The window registers are cleared to 0.
  - Line-buffer RAM contents are don't-care.
  - A PIX_VALID in the same cycle as rst is discarded.
- **Reset mid-frame.** The next accepted pixel is (0,0), with or without SOF. No PATCH_VALID is asserted until row 2, column 2 of the new frame.
- **Simultaneous events.**
  - SOF on the last pixel of a frame: SOF wins; that pixel is treated as (0,0).
  - PIX_VALID low on the wrap cycle: the wrap waits for the next accept.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, DW=16 unless stated.

- **Continuous frame.** Stream pixels 0..15 with PIX_VALID held high and SOF on pixel 0.
  - Exactly 4 PATCH_VALID pulses.
  - The first is one cycle after pixel 10: PATCH={0,1,2,4,5,6,8,9,10}, ROW_O=2, COL_O=2.
  - Then after pixel 11: {1,2,3,5,6,7,9,10,11}.
  - After pixel 14: {4,5,6,8,9,10,12,13,14}.
  - After pixel 15: {5,6,7,9,10,11,13,14,15}.
- **Gapped input.** Same frame with PIX_VALID low on every other cycle. The same 4 patches appear in the same order, each one cycle after its accept. PATCH is held between pulses.
- **Back-to-back frames.** Frame 2 uses pixels 100..115 with no gap and no SOF.
  - The first frame-2 patch is {100,101,102,104,105,106,108,109,110}.
  - No window mixes data from frames 1 and 2.
- **SOF resync.** Assert SOF on the 7th pixel of a frame. That pixel is treated as (0,0). The first PATCH_VALID occurs 10 accepts later, with ROW_O=2 and COL_O=2.
- **Mid-frame reset.** Assert rst for one cycle after 9 pixels, together with PIX_VALID.
  - All outputs read 0 and that pixel is dropped.
  - The next 16 pixels produce the 4 patches expected for a fresh frame.
- **Wider image and end-to-end check.** Run IMG_W=8, IMG_H=8 with pixels 0..63.
  - 36 windows are produced.
  - Feeding PATCH into conv_3_3 with KERNEL={9..17} gives a first RESULT of Σ p·k over {0,1,2,8,9,10,16,17,18}×{9..17}.

Source files
------------

// File: rtl/line_window_3_3.sv
`default_nettype none
// ============================================================================
// Module   : line_window_3_3
// Purpose  : 3x3 sliding-window generator for a raster-order pixel stream.
//            Two line buffers hold the previous two image rows. A 3x3 window
//            register array shifts left by one column on every accepted
//            pixel. Each pixel that completes a full neighbourhood produces
//            one 9*DW-bit patch for the downstream 3x3 convolution stage.
//
// Parameters
//   IMG_W  image width in pixels  (>= 3)
//   IMG_H  image height in pixels (>= 3)
//   DW     pixel width in bits
//
// Ports
//   CLK          in   1           clock, rising edge
//   rst          in   1           synchronous active-high reset
//   PIX_IN       in   DW          input pixel
//   PIX_VALID    in   1           PIX_IN accepted this cycle
//   SOF          in   1           with PIX_VALID: pixel is position (0,0)
//   PATCH        out  9*DW        window; top-left pixel in the MSBs,
//                                 row-major, bottom-right pixel in the LSBs
//   PATCH_VALID  out  1           one-cycle pulse per new window
//   ROW_O        out  clog2(IMG_H) row of the window's bottom-right pixel
//   COL_O        out  clog2(IMG_W) column of the window's bottom-right pixel
//
// Revision : 1.0  initial release
// ============================================================================
module line_window_3_3 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 16
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [DW-1:0]            PIX_IN,
    input  logic                     PIX_VALID,
    input  logic                     SOF,
    output logic [9*DW-1:0]          PATCH,
    output logic                     PATCH_VALID,
    output logic [$clog2(IMG_H)-1:0] ROW_O,
    output logic [$clog2(IMG_W)-1:0] COL_O
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_last_row = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_two_col  = CW'(2);
    localparam logic [RW-1:0] c_two_row  = RW'(2);

    // ------------------------------------------------------------------------
    // Position of the next pixel to accept
    // ------------------------------------------------------------------------
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    // Effective position of the pixel on the input this cycle. SOF forces
    // (0,0) regardless of where the counters currently point.
    logic [RW-1:0] w_pix_row;
    logic [CW-1:0] w_pix_col;
    logic [RW-1:0] w_next_row;
    logic [CW-1:0] w_next_col;
    logic          w_accept;
    logic          w_full_window;

    assign w_accept  = PIX_VALID && !rst;
    assign w_pix_row = SOF ? '0 : r_row;
    assign w_pix_col = SOF ? '0 : r_col;

    // A window is complete only once two rows and two columns precede the
    // current pixel; this also masks stale columns at the start of each row
    // and stale line-buffer rows at the start of a frame.
    assign w_full_window = (w_pix_row >= c_two_row) && (w_pix_col >= c_two_col);

    always_comb begin
        w_next_row = w_pix_row;
        w_next_col = w_pix_col + CW'(1);
        if (w_pix_col == c_last_col) begin
            w_next_col = '0;
            if (w_pix_row == c_last_row) begin
                w_next_row = '0;
            end else begin
                w_next_row = w_pix_row + RW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (PIX_VALID) begin
            r_row <= w_next_row;
            r_col <= w_next_col;
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers: r_lb0 holds row r-1, r_lb1 holds row r-2, both indexed
    // by column. Contents are never cleared; the window-complete condition
    // hides whatever is left from an earlier frame.
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_lb0 [IMG_W];
    logic [DW-1:0] r_lb1 [IMG_W];
    logic [DW-1:0] w_lb0_rd;
    logic [DW-1:0] w_lb1_rd;

    assign w_lb0_rd = r_lb0[w_pix_col];
    assign w_lb1_rd = r_lb1[w_pix_col];

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_lb1[w_pix_col] <= w_lb0_rd;
            r_lb0[w_pix_col] <= PIX_IN;
        end
    end

    // ------------------------------------------------------------------------
    // Window registers: r_win[row][col], row 0 = oldest image row (r-2),
    // col 2 = newest column. The new right column is built from buffer
    // values read before this cycle's write.
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_win [3][3];
    logic          r_win_vld;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_win_vld <= 1'b0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else begin
            r_win_vld <= PIX_VALID && w_full_window;
            if (PIX_VALID) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb1_rd;
                r_win[1][2] <= w_lb0_rd;
                r_win[2][2] <= PIX_IN;
                r_win_row   <= w_pix_row;
                r_win_col   <= w_pix_col;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Patch packing: element k = 3*row + col sits at slot 8-k, so the
    // top-left pixel lands in the MSBs and the bottom-right in the LSBs.
    // ------------------------------------------------------------------------
    logic [9*DW-1:0] w_pack;

    for (genvar gi = 0; gi < 3; gi++) begin : g_pack_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_pack_col
            assign w_pack[(8 - (3*gi + gj))*DW +: DW] = r_win[gi][gj];
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: registers the completed window; PATCH, ROW_O and COL_O
    // hold between pulses.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (rst) begin
            PATCH       <= '0;
            PATCH_VALID <= 1'b0;
            ROW_O       <= '0;
            COL_O       <= '0;
        end else begin
            PATCH_VALID <= r_win_vld;
            if (r_win_vld) begin
                PATCH <= w_pack;
                ROW_O <= r_win_row;
                COL_O <= r_win_col;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_window_3_3.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_3_3
// Purpose  : Directed self-checking bench for line_window_3_3. A 4x4 instance
//            covers streaming, gaps, back-to-back frames, SOF resync and
//            mid-frame reset; an 8x8 instance covers window count and patch
//            ordering through a 3x3 dot product with kernel {9..17}.
// Revision : 1.0  initial release
// ============================================================================
module tb_line_window_3_3;

    localparam int DW = 16;

    typedef struct {
        logic [9*DW-1:0] p;
        int              r;
        int              c;
        int              cyc;
    } rec_t;

    logic            CLK;
    logic            rst;
    logic [DW-1:0]   pix1, pix2;
    logic            pv1, pv2, sof1, sof2;
    logic [9*DW-1:0] patch1, patch2;
    logic            patch_vld1, patch_vld2;
    logic [1:0]      row1, col1;
    logic [2:0]      row2, col2;

    line_window_3_3 #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_dut4 (
        .CLK(CLK), .rst(rst), .PIX_IN(pix1), .PIX_VALID(pv1), .SOF(sof1),
        .PATCH(patch1), .PATCH_VALID(patch_vld1), .ROW_O(row1), .COL_O(col1)
    );

    line_window_3_3 #(.IMG_W(8), .IMG_H(8), .DW(DW)) u_dut8 (
        .CLK(CLK), .rst(rst), .PIX_IN(pix2), .PIX_VALID(pv2), .SOF(sof2),
        .PATCH(patch2), .PATCH_VALID(patch_vld2), .ROW_O(row2), .COL_O(col2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc   = 0;
    int              hold_en = 0;
    int              hold_err = 0;
    logic [9*DW-1:0] prev_patch = '0;
    rec_t            q1[$];
    rec_t            q2[$];
    int              acc[64];

    // Expected window whose bottom-right pixel is (r,c) in a frame where
    // pixel (y,x) has value base + y*w + x.
    function automatic logic [9*DW-1:0] win(int base, int r, int c, int w);
        logic [9*DW-1:0] res;
        res = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                res[(8 - (3*i + j))*DW +: DW] = DW'(base + (r - 2 + i)*w + (c - 2 + j));
        return res;
    endfunction

    // One clock: sample at the falling edge, record any patch pulses.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (patch_vld1) q1.push_back('{patch1, int'(row1), int'(col1), cyc});
        if (patch_vld2) q2.push_back('{patch2, int'(row2), int'(col2), cyc});
        if (hold_en != 0 && !patch_vld1 && patch1 !== prev_patch) hold_err++;
        prev_patch = patch1;
    endtask

    task automatic send(input int v, input logic s);
        tick();
        pix1 = DW'(v); pv1 = 1'b1; sof1 = s;
        pv2 = 1'b0; sof2 = 1'b0;
    endtask

    task automatic send2(input int v, input logic s);
        tick();
        pix2 = DW'(v); pv2 = 1'b1; sof2 = s;
        pv1 = 1'b0; sof1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pv1 = 1'b0; sof1 = 1'b0; pv2 = 1'b0; sof2 = 1'b0;
        end
    endtask

    // Checks four recorded 4x4 patches against a fresh frame of given base.
    // chk_lat enables the one-cycle-after-accept latency check via acc[].
    task automatic check_frame4(input string nm, input int off, input int base, input int chk_lat);
        int er[4] = '{2, 2, 3, 3};
        int ec[4] = '{2, 3, 2, 3};
        for (int k = 0; k < 4; k++) begin
            if (off + k >= q1.size()) begin
                n_cmp++; n_bad++;
                $display("FAIL %s patch%0d missing: got %0d pulses", nm, k, q1.size());
            end else begin
                n_cmp++;
                if (q1[off+k].p !== win(base, er[k], ec[k], 4)) begin
                    n_bad++;
                    $display("FAIL %s patch%0d: got %h expected %h", nm, k, q1[off+k].p, win(base, er[k], ec[k], 4));
                end
                n_cmp++;
                if (q1[off+k].r !== er[k] || q1[off+k].c !== ec[k]) begin
                    n_bad++;
                    $display("FAIL %s pos%0d: got (%0d,%0d) expected (%0d,%0d)", nm, k, q1[off+k].r, q1[off+k].c, er[k], ec[k]);
                end
                if (chk_lat != 0) begin
                    n_cmp++;
                    if (q1[off+k].cyc !== acc[er[k]*4 + ec[k]] + 2) begin
                        n_bad++;
                        $display("FAIL %s latency%0d: got cycle %0d expected %0d", nm, k, q1[off+k].cyc, acc[er[k]*4 + ec[k]] + 2);
                    end
                end
            end
        end
    endtask

    task automatic check_count(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s count: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pv1 = 1'b1; pix1 = 16'h5; sof1 = 1'b0;
        idle(0);
        tick(); tick(); tick();
        n_cmp++;
        if (patch1 !== '0 || patch_vld1 !== 1'b0 || row1 !== 2'd0 || col1 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset4: got patch=%h vld=%b row=%0d col=%0d expected all 0", patch1, patch_vld1, row1, col1);
        end
        n_cmp++;
        if (patch2 !== '0 || patch_vld2 !== 1'b0 || row2 !== 3'd0 || col2 !== 3'd0) begin
            n_bad++;
            $display("FAIL reset8: got patch=%h vld=%b row=%0d col=%0d expected all 0", patch2, patch_vld2, row2, col2);
        end
        rst = 1'b0; pv1 = 1'b0;
        idle(2);
    endtask

    task automatic test_continuous();
        q1.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0);
            acc[i] = cyc;
        end
        idle(4);
        check_count("continuous", q1.size(), 4);
        check_frame4("continuous", 0, 0, 1);
    endtask

    task automatic test_gapped();
        q1.delete();
        hold_err = 0;
        prev_patch = patch1;
        hold_en = 1;
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0);
            acc[i] = cyc;
            idle(1);
        end
        idle(4);
        hold_en = 0;
        check_count("gapped", q1.size(), 4);
        check_frame4("gapped", 0, 0, 1);
        n_cmp++;
        if (hold_err !== 0) begin
            n_bad++;
            $display("FAIL gapped hold: got %0d PATCH changes without PATCH_VALID expected 0", hold_err);
        end
    endtask

    task automatic test_back_to_back();
        q1.delete();
        for (int i = 0; i < 16; i++) send(i, i == 0);
        for (int i = 0; i < 16; i++) send(100 + i, 1'b0);
        idle(4);
        check_count("b2b", q1.size(), 8);
        check_frame4("b2b_f1", 0, 0, 0);
        check_frame4("b2b_f2", 4, 100, 0);
    endtask

    task automatic test_sof_resync();
        q1.delete();
        for (int i = 0; i < 6; i++) send(200 + i, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0);
            acc[i] = cyc;
        end
        idle(4);
        check_count("sof_resync", q1.size(), 4);
        check_frame4("sof_resync", 0, 0, 1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) send(50 + i, 1'b0);
        tick();
        rst = 1'b1; pv1 = 1'b1; pix1 = 16'd999; sof1 = 1'b0;
        tick();
        rst = 1'b0; pv1 = 1'b0;
        n_cmp++;
        if (patch1 !== '0 || patch_vld1 !== 1'b0 || row1 !== 2'd0 || col1 !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_reset outputs: got patch=%h vld=%b row=%0d col=%0d expected all 0", patch1, patch_vld1, row1, col1);
        end
        q1.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, 1'b0);
            acc[i] = cyc;
        end
        idle(4);
        check_count("mid_reset", q1.size(), 4);
        check_frame4("mid_reset", 0, 0, 1);
    endtask

    task automatic test_wide();
        int sum;
        q2.delete();
        for (int i = 0; i < 64; i++) send2(i, i == 0);
        idle(4);
        check_count("wide", q2.size(), 36);
        if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wide first patch missing: got 0 pulses expected 36");
        end else begin
            sum = 0;
            for (int k = 0; k < 9; k++) sum += int'(q2[0].p[(8 - k)*DW +: DW]) * (9 + k);
            n_cmp++;
            if (sum !== 1203) begin
                n_bad++;
                $display("FAIL wide conv: got %0d expected 1203", sum);
            end
            n_cmp++;
            if (q2[0].r !== 2 || q2[0].c !== 2) begin
                n_bad++;
                $display("FAIL wide first pos: got (%0d,%0d) expected (2,2)", q2[0].r, q2[0].c);
            end
            n_cmp++;
            if (q2[q2.size()-1].p !== win(0, 7, 7, 8) || q2[q2.size()-1].r !== 7 || q2[q2.size()-1].c !== 7) begin
                n_bad++;
                $display("FAIL wide last: got %h at (%0d,%0d) expected %h at (7,7)",
                         q2[q2.size()-1].p, q2[q2.size()-1].r, q2[q2.size()-1].c, win(0, 7, 7, 8));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pix1 = '0; pix2 = '0;
        pv1 = 1'b0; pv2 = 1'b0; sof1 = 1'b0; sof2 = 1'b0;
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_sof_resync();
        test_mid_reset();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
